// File: rtl/uart_tx_if.sv
// Byte handshake between the upstream ring buffer and the UART transmit stage.
//   data_in_data   byte offered by upstream (DATA_WIDTH bits)
//   data_in_valid  upstream has a byte
//   data_in_ready  transmit stage accepts the byte this cycle
// Modports: master = upstream producer, slave = uart_tx.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in_data;
    logic                  data_in_valid;
    logic                  data_in_ready;

    modport master (
        output data_in_data,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in_data,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// Serial transmit stage: start bit, data LSB first, optional parity, stop bit(s).
// Back-pressures upstream while a frame is in flight; a byte offered on the
// final cycle of the final stop bit starts the next frame with no idle gap.
//   clk      clock, all state on posedge
//   rst      synchronous active-low reset
//   data_in  byte handshake (uart_tx_if slave modport)
//   tx       registered serial line, idles high
//   busy     registered, high while a frame is in flight
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, ready for a byte
// S_START | driving start bit (0)
// S_DATA  | driving shift register bit 0, idx = data bit
// S_PARITY| driving parity bit
// S_STOP  | driving stop bit(s) (1), idx = stop bit number
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   data_in,
    output logic       tx,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_d;
    logic                  wrap;
    logic                  ready_int;
    logic                  accept;

    assign wrap      = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign ready_int = (state_q == S_IDLE) ||
                       ((state_q == S_STOP) && (idx_q == IW'(STOP_BITS - 1)) && wrap);
    assign data_in.data_in_ready = rst && ready_int;
    assign accept = data_in.data_in_valid && data_in.data_in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept overrides the stop-bit exit so frames chain without a gap.
        if (accept) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = data_in.data_in_data;
            par_d   = (^data_in.data_in_data) ^ (PARITY == 1);
        end

        // tx is registered, so it is derived from the next state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx      <= tx_d;
            busy    <= (state_d != S_IDLE);
        end
    end
endmodule
